// File: rtl/pmem_pkg.sv
// Shared constants and state encoding for the program memory loader.
package pmem_pkg;

  localparam int PMEM_ADDR_W  = 8;
  localparam int PMEM_INSTR_W = 12;

  // Upper nibble of the HI byte is reserved for the default 12-bit instruction.
  localparam logic [7:0] HI_RSVD_MASK = 8'hF0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4
  } pmem_state_e;

endpackage

// File: rtl/pmem_loader.sv
// Program memory load master: packs HI/LO byte pairs into instructions, writes sequential addresses.
// Latency: o_Len pulses 1 cycle after the LO byte is accepted; optional trailing checksum via PMEM_LOADER_CSUM_EN.
// Backpressure: o_Byte_Ready is high only in byte-consuming states; stalls on i_Byte_Valid are harmless.
module pmem_loader
  import pmem_pkg::*;
#(
  parameter int ADDR_W  = PMEM_ADDR_W,
  parameter int INSTR_W = PMEM_INSTR_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_Start,
  input  logic [ADDR_W-1:0]  i_Start_Addr,
  input  logic [ADDR_W-1:0]  i_Count,
  input  logic [7:0]         i_Byte,
  input  logic               i_Byte_Valid,
  output logic               o_Byte_Ready,
  output logic               o_Len,
  output logic [ADDR_W-1:0]  o_L_Addr,
  output logic [INSTR_W-1:0] o_L_Instr,
  output logic               o_Hold,
  output logic               o_Done,
  output logic               o_Err
);

  localparam int HI_W = INSTR_W - 8;

  // Reserved bits above the instruction's high field; empty when INSTR_W is 16.
  localparam logic [15:0] RSVD_WIDE = 16'h00FF << HI_W;
  localparam logic [7:0]  RSVD_MASK = (INSTR_W == PMEM_INSTR_W) ? HI_RSVD_MASK : RSVD_WIDE[7:0];

  localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  pmem_state_e        state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W:0]    rem_q, rem_d;
  logic [HI_W-1:0]    instr_hi_q, instr_hi_d;
  logic               len_q, len_d;
  logic [ADDR_W-1:0]  l_addr_q, l_addr_d;
  logic [INSTR_W-1:0] l_instr_q, l_instr_d;
  logic               hold_q, hold_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               byte_rdy;
`ifdef PMEM_LOADER_CSUM_EN
  logic [7:0]         sum_q, sum_d;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      instr_hi_q <= '0;
      len_q      <= 1'b0;
      l_addr_q   <= '0;
      l_instr_q  <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef PMEM_LOADER_CSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      instr_hi_q <= instr_hi_d;
      len_q      <= len_d;
      l_addr_q   <= l_addr_d;
      l_instr_q  <= l_instr_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef PMEM_LOADER_CSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    instr_hi_d = instr_hi_q;
    len_d      = 1'b0;
    l_addr_d   = l_addr_q;
    l_instr_d  = l_instr_q;
    hold_d     = hold_q;
    done_d     = 1'b0;
    err_d      = err_q;
    byte_rdy   = 1'b0;
`ifdef PMEM_LOADER_CSUM_EN
    sum_d      = sum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          addr_d  = i_Start_Addr;
          rem_d   = (i_Count == '0) ? FULL_CNT : {1'b0, i_Count};
          err_d   = 1'b0;
          hold_d  = 1'b1;
          state_d = ST_HI;
`ifdef PMEM_LOADER_CSUM_EN
          sum_d   = '0;
`endif
        end
      end

      ST_HI: begin
        byte_rdy = 1'b1;
        if (i_Byte_Valid) begin
          if ((i_Byte & RSVD_MASK) != 8'h00) begin
            err_d   = 1'b1;
            hold_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            instr_hi_d = i_Byte[HI_W-1:0];
            state_d    = ST_LO;
`ifdef PMEM_LOADER_CSUM_EN
            sum_d      = sum_q + i_Byte;
`endif
          end
        end
      end

      ST_LO: begin
        byte_rdy = 1'b1;
        if (i_Byte_Valid) begin
          len_d     = 1'b1;
          l_addr_d  = addr_q;
          l_instr_d = {instr_hi_q, i_Byte};
          addr_d    = addr_q + ADDR_ONE;
          rem_d     = rem_q - REM_ONE;
`ifdef PMEM_LOADER_CSUM_EN
          sum_d     = sum_q + i_Byte;
`endif
          if (rem_q == REM_ONE) begin
`ifdef PMEM_LOADER_CSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_HI;
          end
        end
      end

`ifdef PMEM_LOADER_CSUM_EN
      ST_CSUM: begin
        byte_rdy = 1'b1;
        if (i_Byte_Valid) begin
          if (i_Byte == sum_q) begin
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b1;
            hold_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
`endif

      ST_DONE: begin
        // Hold stays up through the last write pulse and drops with o_Done.
        done_d  = 1'b1;
        hold_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        hold_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_Byte_Ready = byte_rdy;
  assign o_Len        = len_q;
  assign o_L_Addr     = l_addr_q;
  assign o_L_Instr    = l_instr_q;
  assign o_Hold       = hold_q;
  assign o_Done       = done_q;
  assign o_Err        = err_q;

endmodule
